// File: rtl/tans_huffman_decoder_if.sv
// Handshake bundle for tans_huffman_decoder: run control, LIFO bit fetch, Huffman bit output.
// The master side drives runs and supplies bits; the slave side is the decoder.
interface tans_huffman_decoder_if #(
    parameter int unsigned CW = 8
) ();
    logic          start;
    logic [3:0]    init_state;
    logic [CW-1:0] sym_count;
    logic [2:0]    in_bits;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    need;
    logic          o_bit;
    logic          o_valid;
    logic          o_ready;
    logic          busy;
    logic          done;
    logic          err;
    logic [3:0]    state_out;

    modport master (
        output start, init_state, sym_count, in_bits, in_valid, o_ready,
        input  in_ready, need, o_bit, o_valid, busy, done, err, state_out
    );

    modport slave (
        input  start, init_state, sym_count, in_bits, in_valid, o_ready,
        output in_ready, need, o_bit, o_valid, busy, done, err, state_out
    );
endinterface

// File: rtl/tans_huffman_decoder.sv
// Walks the 8-state tANS decode table (LA=5, LB=2, LC=1) from the final encoder state,
// re-emitting symbols as serial Huffman codes A=0, B=10, C=11 in reverse encode order.
module tans_huffman_decoder #(
    parameter int unsigned CW = 8
) (
    input logic                     PHI,
    input logic                     RST,
    tans_huffman_decoder_if.slave   bus
);

    typedef enum logic [2:0] {StIdle, StLookup, StEmit, StFetch, StDone} state_e;

    state_e        state_q, state_d;
    logic [3:0]    x_q, x_d;
    logic [CW-1:0] rem_q, rem_d;
    logic          len2_q, len2_d;
    logic          lo_q, lo_d;
    logic [3:0]    xs_q, xs_d;
    logic [1:0]    nb_q, nb_d;
    logic          bit_idx_q, bit_idx_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [3:0]    state_out_q, state_out_d;

    logic          t_len2, t_lo;
    logic [3:0]    t_xs;
    logic [1:0]    t_nb;
    logic [2:0]    fetch_mask;
    logic [3:0]    fetch_x;
    logic          last_bit;

    // Decode table: len2/lo encode the Huffman code (A: len1, B: 10, C: 11).
    always_comb begin
        t_len2 = 1'b0;
        t_lo   = 1'b0;
        t_xs   = 4'd0;
        t_nb   = 2'd0;
        case (x_q)
            4'd8:  begin t_xs = 4'd5; t_nb = 2'd1; end
            4'd9:  begin t_xs = 4'd6; t_nb = 2'd1; end
            4'd10: begin t_xs = 4'd7; t_nb = 2'd1; end
            4'd11: begin t_xs = 4'd8; t_nb = 2'd0; end
            4'd12: begin t_xs = 4'd9; t_nb = 2'd0; end
            4'd13: begin t_len2 = 1'b1; t_xs = 4'd2; t_nb = 2'd2; end
            4'd14: begin t_len2 = 1'b1; t_xs = 4'd3; t_nb = 2'd2; end
            4'd15: begin t_len2 = 1'b1; t_lo = 1'b1; t_xs = 4'd1; t_nb = 2'd3; end
            default: ;
        endcase
    end

    always_comb begin
        case (nb_q)
            2'd1:    fetch_mask = 3'b001;
            2'd2:    fetch_mask = 3'b011;
            2'd3:    fetch_mask = 3'b111;
            default: fetch_mask = 3'b000;
        endcase
        fetch_x  = (xs_q << nb_q) | {1'b0, bus.in_bits & fetch_mask};
        last_bit = len2_q ? bit_idx_q : 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        rem_d       = rem_q;
        len2_d      = len2_q;
        lo_d        = lo_q;
        xs_d        = xs_q;
        nb_d        = nb_q;
        bit_idx_d   = bit_idx_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        state_out_d = state_out_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (!bus.init_state[3]) begin
                        err_d = 1'b1;
                    end else if (bus.sym_count == '0) begin
                        done_d      = 1'b1;
                        state_out_d = bus.init_state;
                    end else begin
                        x_d     = bus.init_state;
                        rem_d   = bus.sym_count;
                        state_d = StLookup;
                    end
                end
            end
            StLookup: begin
                len2_d    = t_len2;
                lo_d      = t_lo;
                xs_d      = t_xs;
                nb_d      = t_nb;
                bit_idx_d = 1'b0;
                rem_d     = rem_q - 1'b1;
                state_d   = StEmit;
            end
            StEmit: begin
                if (bus.o_ready) begin
                    if (!last_bit) begin
                        bit_idx_d = 1'b1;
                    end else if (rem_q == '0) begin
                        // Last symbol: its refill bits belong to no symbol, so never fetch.
                        done_d      = 1'b1;
                        state_out_d = x_q;
                        state_d     = StDone;
                    end else if (nb_q == 2'd0) begin
                        x_d     = xs_q;
                        state_d = StLookup;
                    end else begin
                        state_d = StFetch;
                    end
                end
            end
            StFetch: begin
                if (bus.in_valid) begin
                    x_d     = fetch_x;
                    state_d = StLookup;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge PHI or posedge RST) begin
        if (RST) begin
            state_q     <= StIdle;
            x_q         <= 4'd0;
            rem_q       <= '0;
            len2_q      <= 1'b0;
            lo_q        <= 1'b0;
            xs_q        <= 4'd0;
            nb_q        <= 2'd0;
            bit_idx_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            state_out_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            rem_q       <= rem_d;
            len2_q      <= len2_d;
            lo_q        <= lo_d;
            xs_q        <= xs_d;
            nb_q        <= nb_d;
            bit_idx_q   <= bit_idx_d;
            done_q      <= done_d;
            err_q       <= err_d;
            state_out_q <= state_out_d;
        end
    end

    assign bus.in_ready  = (state_q == StFetch);
    assign bus.need      = (state_q == StFetch) ? nb_q : 2'd0;
    assign bus.o_valid   = (state_q == StEmit);
    assign bus.o_bit     = (state_q == StEmit) && len2_q && (bit_idx_q ? lo_q : 1'b1);
    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.state_out = state_out_q;

endmodule

// File: tb/tb_tans_huffman_decoder.sv
// Scoreboard bench for tans_huffman_decoder: expected Huffman bits and fetch requests are
// queued at stimulus time and consumed as the decoder emits bits and requests refills.
module tb_tans_huffman_decoder;
    localparam int unsigned CW = 8;

    logic PHI = 1'b0;
    logic RST = 1'b1;

    tans_huffman_decoder_if #(.CW(CW)) bus ();

    tans_huffman_decoder #(.CW(CW)) dut (
        .PHI (PHI),
        .RST (RST),
        .bus (bus)
    );

    always #5 PHI = ~PHI;

    int tests = 0;
    int fails = 0;

    bit         exp_bits[$];
    logic [2:0] fetch_q[$];
    logic [1:0] need_q[$];

    int         fetch_cnt, done_cnt, err_cnt;
    logic [3:0] last_so;
    bit         busy_seen;
    bit         rdy_en = 1'b1;
    bit         fetch_en = 1'b1;
    bit         start_req = 1'b0;
    logic [3:0] req_init = 4'd0;
    logic [7:0] req_cnt = 8'd0;

    // One cycle: drive inputs just after the falling edge, then score what the DUT shows.
    task automatic step();
        bit         b;
        logic [1:0] n;
        @(negedge PHI);
        bus.o_ready    = rdy_en;
        bus.start      = start_req;
        bus.init_state = req_init;
        bus.sym_count  = req_cnt;
        start_req      = 1'b0;
        if (RST) return;
        if (bus.busy) busy_seen = 1'b1;
        if (bus.done) begin
            done_cnt++;
            last_so = bus.state_out;
        end
        if (bus.err) err_cnt++;
        if (bus.o_valid && bus.o_ready) begin
            tests++;
            if (exp_bits.size() == 0) begin
                fails++;
                $display("FAIL obit_extra: got o_bit=%0b, required no bit", bus.o_bit);
            end else begin
                b = exp_bits.pop_front();
                if (bus.o_bit !== b) begin
                    fails++;
                    $display("FAIL obit: got %0b, required %0b", bus.o_bit, b);
                end
            end
        end
        if (bus.in_ready && fetch_en) begin
            tests++;
            if (need_q.size() == 0) begin
                fails++;
                $display("FAIL fetch_extra: got need=%0d, required no fetch", bus.need);
                bus.in_bits = 3'b000;
            end else begin
                n = need_q.pop_front();
                if (bus.need !== n) begin
                    fails++;
                    $display("FAIL need: got %0d, required %0d", bus.need, n);
                end
                bus.in_bits = fetch_q.pop_front();
            end
            bus.in_valid = 1'b1;
            fetch_cnt++;
        end else begin
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic start_run(input logic [3:0] init, input logic [7:0] cnt);
        fetch_cnt = 0;
        done_cnt  = 0;
        err_cnt   = 0;
        busy_seen = 1'b0;
        last_so   = 4'hx;
        req_init  = init;
        req_cnt   = cnt;
        start_req = 1'b1;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 100 && done_cnt == 0; i++) step();
        for (int i = 0; i < 3; i++) step();
        tests++;
        if (done_cnt != 1) begin
            fails++;
            $display("FAIL %s_done: got %0d done pulses, required 1", name, done_cnt);
        end
    endtask

    task automatic check_end(input string name, input logic [3:0] so, input int fetches);
        tests++;
        if (exp_bits.size() != 0) begin
            fails++;
            $display("FAIL %s_bits: got %0d bits missing, required 0", name, exp_bits.size());
        end
        tests++;
        if (last_so !== so) begin
            fails++;
            $display("FAIL %s_state_out: got %0d, required %0d", name, last_so, so);
        end
        tests++;
        if (fetch_cnt != fetches) begin
            fails++;
            $display("FAIL %s_fetches: got %0d, required %0d", name, fetch_cnt, fetches);
        end
        exp_bits.delete();
        fetch_q.delete();
        need_q.delete();
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.init_state = 4'd0; bus.sym_count = '0;
        bus.in_bits = 3'b0; bus.in_valid = 1'b0; bus.o_ready = 1'b1;
        #1;
        tests++;
        if ({bus.in_ready, bus.need, bus.o_bit, bus.o_valid, bus.busy, bus.done, bus.err,
             bus.state_out} !== 12'd0) begin
            fails++;
            $display("FAIL reset_outputs: got busy=%0b o_valid=%0b state_out=%0d, required 0",
                     bus.busy, bus.o_valid, bus.state_out);
        end
        @(negedge PHI);
        RST = 1'b0;
    endtask

    task automatic test_fetch2();
        exp_bits = '{1, 0, 0, 1, 0};
        need_q   = '{2'd2, 2'd1};
        fetch_q  = '{3'b001, 3'b001};
        start_run(4'd13, 8'd3);
        wait_done("fetch2");
        check_end("fetch2", 4'd13, 2);
    endtask

    task automatic test_fetch3();
        exp_bits = '{1, 1, 0};
        need_q   = '{2'd3};
        fetch_q  = '{3'b010};
        start_run(4'd15, 8'd2);
        wait_done("fetch3");
        check_end("fetch3", 4'd10, 1);
    endtask

    task automatic test_no_fetch();
        exp_bits = '{0};
        start_run(4'd12, 8'd1);
        wait_done("nofetch12");
        check_end("nofetch12", 4'd12, 0);
        exp_bits = '{0, 0};
        start_run(4'd11, 8'd2);
        wait_done("nofetch11");
        check_end("nofetch11", 4'd8, 0);
    endtask

    task automatic test_backpressure();
        exp_bits = '{1, 0, 0};
        need_q   = '{2'd2};
        fetch_q  = '{3'b101};  // bit 2 must be ignored: X = 8 | 1 = 9
        rdy_en   = 1'b0;
        fetch_en = 1'b0;
        start_run(4'd13, 8'd2);
        for (int i = 0; i < 20 && !bus.o_valid; i++) step();
        for (int i = 0; i < 5; i++) begin
            step();
            tests++;
            if (bus.o_valid !== 1'b1 || bus.o_bit !== 1'b1) begin
                fails++;
                $display("FAIL bp_hold: got o_valid=%0b o_bit=%0b, required 1 1",
                         bus.o_valid, bus.o_bit);
            end
        end
        rdy_en = 1'b1;
        for (int i = 0; i < 20 && !bus.in_ready; i++) step();
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (bus.in_ready !== 1'b1 || bus.need !== 2'd2) begin
                fails++;
                $display("FAIL bp_need_hold: got in_ready=%0b need=%0d, required 1 2",
                         bus.in_ready, bus.need);
            end
        end
        fetch_en = 1'b1;
        wait_done("bp");
        check_end("bp", 4'd9, 1);
    endtask

    task automatic test_errors();
        start_run(4'd5, 8'd3);
        for (int i = 0; i < 5; i++) step();
        tests++;
        if (err_cnt != 1 || busy_seen) begin
            fails++;
            $display("FAIL err_pulse: got err=%0d busy_seen=%0b, required 1 0", err_cnt, busy_seen);
        end
        start_run(4'd9, 8'd0);
        for (int i = 0; i < 5; i++) step();
        tests++;
        if (done_cnt != 1 || busy_seen || last_so !== 4'd9) begin
            fails++;
            $display("FAIL zero_count: got done=%0d busy_seen=%0b state_out=%0d, required 1 0 9",
                     done_cnt, busy_seen, last_so);
        end
    endtask

    task automatic test_start_while_busy();
        exp_bits = '{1, 0, 0, 1, 0};
        need_q   = '{2'd2, 2'd1};
        fetch_q  = '{3'b001, 3'b001};
        start_run(4'd13, 8'd3);
        for (int i = 0; i < 3; i++) step();
        req_init  = 4'd8;
        req_cnt   = 8'd5;
        start_req = 1'b1;
        wait_done("busy_start");
        check_end("busy_start", 4'd13, 2);
    endtask

    task automatic test_reset_mid_run();
        exp_bits = '{1, 0, 0, 1, 0};
        start_run(4'd13, 8'd3);
        for (int i = 0; i < 20 && !bus.o_valid; i++) step();
        RST = 1'b1;
        #1;
        tests++;
        if ({bus.in_ready, bus.need, bus.o_bit, bus.o_valid, bus.busy, bus.done, bus.err,
             bus.state_out} !== 12'd0) begin
            fails++;
            $display("FAIL reset_mid: got busy=%0b o_valid=%0b state_out=%0d, required 0",
                     bus.busy, bus.o_valid, bus.state_out);
        end
        exp_bits.delete();
        fetch_q.delete();
        need_q.delete();
        step();
        RST = 1'b0;
        test_fetch2();
    endtask

    initial begin
        test_reset();
        test_fetch2();
        test_fetch3();
        test_no_fetch();
        test_backpressure();
        test_errors();
        test_start_while_busy();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tans_huffman_decoder.md
Name: tans_huffman_decoder

Overview:
- Inverse of the team's Huffman-to-tANS recoder. Takes the encoder's final tANS state and the emitted tANS bit chunks, supplied in reverse order by an upstream LIFO.
- Walks the tANS decode table and re-emits the symbols as a serial Huffman bit stream: A=0, B=10, C=11.
- Uses the same 8-state table (L=8, states 8..15) with counts LA=5, LB=2, LC=1.
- Symbols come out in reverse of encode order.

Parameters:
- CW, 8, width of the symbol-count input and of the internal remaining-symbol counter.

Ports:
- PHI  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- start  in  1  begin a decode run; sampled in IDLE only.
- init_state  in  4  starting tANS state; must be 8..15.
- sym_count  in  CW  number of symbols to decode.
- in_bits  in  3  fetched stream bits, right-justified; only the low `need` bits are used.
- in_valid  in  1  in_bits valid.
- in_ready  out  1  decoder is requesting bits; high only in FETCH.
- need  out  2  number of bits requested (0..3); 0 outside FETCH.
- o_bit  out  1  Huffman output bit.
- o_valid  out  1  o_bit valid.
- o_ready  in  1  downstream accepts o_bit.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a run completes.
- err  out  1  one-cycle pulse when start is given with init_state < 8.
- state_out  out  4  state X at the final lookup; held until the next start.

Behaviour:
- Reset (asynchronous, any state): FSM=IDLE; X=0; remaining=0; all outputs 0, including state_out.
- Decode table, X -> (sym, xs, nb):
  - 8->(A,5,1), 9->(A,6,1), 10->(A,7,1), 11->(A,8,0), 12->(A,9,0)
  - 13->(B,2,2), 14->(B,3,2)
  - 15->(C,1,3)
  - nb = 3 - floor(log2 xs).
- State X updates:
  - next X = xs when nb=0.
  - next X = (xs<<nb) | in_bits[nb-1:0] otherwise; the result is always in 8..15.
- IDLE:
  - start with init_state[3]=0 -> err=1 for one cycle, stay IDLE.
  - start with sym_count=0 -> done=1, state_out=init_state, stay IDLE.
  - Otherwise -> X=init_state, remaining=sym_count, go to LOOKUP.
- LOOKUP (1 cycle): register sym, xs, nb from X; remaining -= 1; go to EMIT.
- EMIT:
  - Drive the code bits MSB-first; o_valid=1 throughout.
  - A bit is consumed on the cycle o_valid & o_ready.
  - o_bit and o_valid hold stable while o_ready=0.
  - After the last code bit is accepted:
    - remaining=0 -> DONE; the last symbol never fetches bits.
    - else nb=0 -> X=xs, go to LOOKUP.
    - else -> FETCH.
- FETCH: in_ready=1, need=nb. When in_valid is high, X is updated per the rule above, then go to LOOKUP. in_bits bits above nb are ignored.
- DONE (1 cycle): done=1, state_out=X, then IDLE.
- start while busy is ignored.
- Minimum throughput per symbol: 1 + (code length) + (nb>0 ? 1 : 0) cycles, assuming o_ready and in_valid are held high.

Test Plan:
- Decode with 2-bit fetches: init_state=13, sym_count=3, in_bits supplied 2'b01 then 3'b001 (need=1 uses only bit 0).
  - Required: o_bit stream 1,0,0,1,0.
  - Required: need sequence 2 then 1.
  - Required: done pulse, state_out=13.
- Decode with 3-bit fetch: init_state=15, sym_count=2, in_bits=3'b010.
  - Required: o_bits 1,1,0; exactly one fetch with need=3.
  - Required: state_out=10; in_ready never asserts after the last symbol.
- Decode with no fetches: init_state=12, sym_count=1.
  - Required: o_bit 0, done, no fetch, state_out=12.
  - Repeat with init_state=11, sym_count=2: X 11 -> 8, o_bits 0,0, then one need=1 fetch is NOT issued (last symbol); state_out=8.
- Backpressure: o_ready held low 5 cycles mid-B code.
  - Required: o_bit=1 and o_valid held stable.
  - Required: no bit lost or duplicated; with in_valid held low in FETCH, need stays 2.
- Error and edge cases:
  - init_state=5 -> err pulse, busy stays 0.
  - sym_count=0 -> done pulse only.
  - start asserted while busy -> no effect.
- Reset mid-run: RST asserted during EMIT.
  - Required: all outputs 0 immediately; FSM IDLE.
  - Required: a subsequent run with init_state=13 decodes correctly.
